// File: rtl/ibex_rf_wb_pkg.sv
// ibex_rf_wb_pkg
//   Shared definitions for the register-file writeback stage.
//   - REG_ADDR_W : width of a register address.
//   - WB_DATA_W  : width of the data field carried in a write request.
//                  The stage supports DataWidth values up to this width.
//   - wb_state_e : load scoreboard state (idle / one load outstanding).
//   - wb_req_t   : one register-file write request {we, waddr, wdata}.
package ibex_rf_wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int WB_DATA_W  = 32;

    typedef enum logic [0:0] {
        WB_IDLE         = 1'b0,
        WB_LOAD_PENDING = 1'b1
    } wb_state_e;

    typedef struct packed {
        logic                  we;
        logic [REG_ADDR_W-1:0] waddr;
        logic [WB_DATA_W-1:0]  wdata;
    } wb_req_t;

endpackage

// File: rtl/ibex_wb_scoreboard.sv
// ibex_wb_scoreboard
//   Tracks the destination of the single outstanding load and tells decode
//   when it must stall because it reads that register.
//   Inputs : clk_i, rst_i (async, active-high), lsu_req_i / lsu_waddr_i
//            (load issue), lsu_rvalid_i (load response), raddr_a_i /
//            raddr_b_i (decode read addresses).
//   Outputs: state_o (WB_IDLE / WB_LOAD_PENDING), pend_waddr_o,
//            lsu_req_ready_o, hazard_o.
//   Handshake: a load is issued in a cycle where lsu_req_i and
//   lsu_req_ready_o are both high; a request without ready is ignored.
module ibex_wb_scoreboard
    import ibex_rf_wb_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  lsu_req_i,
    input  logic [REG_ADDR_W-1:0] lsu_waddr_i,
    input  logic                  lsu_rvalid_i,
    input  logic [REG_ADDR_W-1:0] raddr_a_i,
    input  logic [REG_ADDR_W-1:0] raddr_b_i,
    output wb_state_e             state_o,
    output logic [REG_ADDR_W-1:0] pend_waddr_o,
    output logic                  lsu_req_ready_o,
    output logic                  hazard_o
);

    wb_state_e             state_q;
    logic [REG_ADDR_W-1:0] pend_waddr_q;
    logic                  pending;
    logic                  req_accept;

    assign pending    = (state_q == WB_LOAD_PENDING);
    // A response retiring the current load frees the slot in the same cycle.
    assign lsu_req_ready_o = !pending || lsu_rvalid_i;
    assign req_accept      = lsu_req_i && lsu_req_ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= WB_IDLE;
            pend_waddr_q <= '0;
        end else if (req_accept) begin
            // Also covers response + new request in one cycle.
            state_q      <= WB_LOAD_PENDING;
            pend_waddr_q <= lsu_waddr_i;
        end else if (lsu_rvalid_i) begin
            state_q      <= WB_IDLE;
        end
    end

    // A response arriving now clears the stall; its data is forwarded from
    // the write stage in the next cycle.
    assign hazard_o = pending && !lsu_rvalid_i && (pend_waddr_q != '0) &&
                      ((raddr_a_i == pend_waddr_q) || (raddr_b_i == pend_waddr_q));

    assign state_o      = state_q;
    assign pend_waddr_o = pend_waddr_q;

endmodule

// File: rtl/ibex_rf_wb_stage.sv
// ibex_rf_wb_stage
//   Writeback stage in front of the flop-based register file. Arbitrates
//   between execute results and load responses (load response wins),
//   registers the selected write onto the register-file write port, and
//   forwards that in-flight write to decode.
//   Execute side : ex_valid_i, ex_we_i, ex_waddr_i, ex_wdata_i -> ex_ready_o
//   LSU side     : lsu_req_i, lsu_waddr_i -> lsu_req_ready_o;
//                  lsu_rvalid_i, lsu_rdata_i, lsu_err_i
//   Decode side  : raddr_a_i, raddr_b_i -> fwd_a_valid_o, fwd_b_valid_o,
//                  fwd_data_o, hazard_o
//   RF write port: rf_waddr_o, rf_wdata_o, rf_we_o (one cycle after select)
//   Status pulses: load_err_o, illegal_waddr_o, spurious_rsp_o
//   Handshake: an execute result transfers in a cycle with ex_valid_i and
//   ex_ready_o high; upstream holds ex_* stable while ex_ready_o is low.
module ibex_rf_wb_stage
    import ibex_rf_wb_pkg::*;
#(
    parameter bit RV32E     = 1'b0,
    parameter int DataWidth = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ex_valid_i,
    input  logic                  ex_we_i,
    input  logic [REG_ADDR_W-1:0] ex_waddr_i,
    input  logic [DataWidth-1:0]  ex_wdata_i,
    output logic                  ex_ready_o,
    input  logic                  lsu_req_i,
    input  logic [REG_ADDR_W-1:0] lsu_waddr_i,
    output logic                  lsu_req_ready_o,
    input  logic                  lsu_rvalid_i,
    input  logic [DataWidth-1:0]  lsu_rdata_i,
    input  logic                  lsu_err_i,
    input  logic [REG_ADDR_W-1:0] raddr_a_i,
    input  logic [REG_ADDR_W-1:0] raddr_b_i,
    output logic [REG_ADDR_W-1:0] rf_waddr_o,
    output logic [DataWidth-1:0]  rf_wdata_o,
    output logic                  rf_we_o,
    output logic                  fwd_a_valid_o,
    output logic                  fwd_b_valid_o,
    output logic [DataWidth-1:0]  fwd_data_o,
    output logic                  hazard_o,
    output logic                  load_err_o,
    output logic                  illegal_waddr_o,
    output logic                  spurious_rsp_o
);

    wb_state_e             sb_state;
    logic [REG_ADDR_W-1:0] pend_waddr;
    logic                  pending;
    logic                  lsu_sel;
    logic                  illegal;
    wb_req_t               sel_req;
    wb_req_t               wr_q;
    logic                  load_err_q;
    logic                  illegal_q;
    logic                  spurious_q;

    ibex_wb_scoreboard u_scoreboard (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .lsu_req_i       (lsu_req_i),
        .lsu_waddr_i     (lsu_waddr_i),
        .lsu_rvalid_i    (lsu_rvalid_i),
        .raddr_a_i       (raddr_a_i),
        .raddr_b_i       (raddr_b_i),
        .state_o         (sb_state),
        .pend_waddr_o    (pend_waddr),
        .lsu_req_ready_o (lsu_req_ready_o),
        .hazard_o        (hazard_o)
    );

    assign pending = (sb_state == WB_LOAD_PENDING);
    // Only a response that retires a real load competes for the write port.
    assign lsu_sel    = lsu_rvalid_i && pending;
    assign ex_ready_o = !lsu_sel;

    always_comb begin
        sel_req = '0;
        if (lsu_sel) begin
            sel_req.we    = !lsu_err_i;
            sel_req.waddr = pend_waddr;
            sel_req.wdata = WB_DATA_W'(lsu_rdata_i);
        end else if (ex_valid_i) begin
            sel_req.we    = ex_we_i;
            sel_req.waddr = ex_waddr_i;
            sel_req.wdata = WB_DATA_W'(ex_wdata_i);
        end
    end

    // RV32E has only x0..x15; a requested write beyond that is dropped.
    assign illegal = RV32E && sel_req.we && sel_req.waddr[REG_ADDR_W-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q       <= '0;
            load_err_q <= 1'b0;
            illegal_q  <= 1'b0;
            spurious_q <= 1'b0;
        end else begin
            wr_q.we <= sel_req.we && (sel_req.waddr != '0) && !illegal;
            // Address/data only move on a real write so fwd_data_o keeps
            // the last written value otherwise.
            if (sel_req.we && (sel_req.waddr != '0) && !illegal) begin
                wr_q.waddr <= sel_req.waddr;
                wr_q.wdata <= sel_req.wdata;
            end
            load_err_q <= lsu_sel && lsu_err_i;
            illegal_q  <= illegal;
            spurious_q <= lsu_rvalid_i && !pending;
        end
    end

    assign rf_we_o    = wr_q.we;
    assign rf_waddr_o = wr_q.waddr;
    assign rf_wdata_o = DataWidth'(wr_q.wdata);
    assign fwd_data_o = rf_wdata_o;

    // The register file only updates at the next edge, so decode takes the
    // in-flight value from here.
    assign fwd_a_valid_o = rf_we_o && (rf_waddr_o == raddr_a_i) && (raddr_a_i != '0);
    assign fwd_b_valid_o = rf_we_o && (rf_waddr_o == raddr_b_i) && (raddr_b_i != '0);

    assign load_err_o      = load_err_q;
    assign illegal_waddr_o = illegal_q;
    assign spurious_rsp_o  = spurious_q;

endmodule

// File: tb/tb_ibex_rf_wb_stage.sv
// tb_ibex_rf_wb_stage
//   Directed bench for ibex_rf_wb_stage built with RV32E=1. Inputs change
//   1 time unit after the rising edge; outputs are checked 1 unit later.
module tb_ibex_rf_wb_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ex_valid_i, ex_we_i;
    logic [4:0]  ex_waddr_i;
    logic [31:0] ex_wdata_i;
    logic        ex_ready_o;
    logic        lsu_req_i;
    logic [4:0]  lsu_waddr_i;
    logic        lsu_req_ready_o;
    logic        lsu_rvalid_i;
    logic [31:0] lsu_rdata_i;
    logic        lsu_err_i;
    logic [4:0]  raddr_a_i, raddr_b_i;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        rf_we_o;
    logic        fwd_a_valid_o, fwd_b_valid_o;
    logic [31:0] fwd_data_o;
    logic        hazard_o, load_err_o, illegal_waddr_o, spurious_rsp_o;

    int n_checks = 0;
    int n_fail   = 0;

    ibex_rf_wb_stage #(.RV32E(1'b1), .DataWidth(32)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .ex_valid_i      (ex_valid_i),
        .ex_we_i         (ex_we_i),
        .ex_waddr_i      (ex_waddr_i),
        .ex_wdata_i      (ex_wdata_i),
        .ex_ready_o      (ex_ready_o),
        .lsu_req_i       (lsu_req_i),
        .lsu_waddr_i     (lsu_waddr_i),
        .lsu_req_ready_o (lsu_req_ready_o),
        .lsu_rvalid_i    (lsu_rvalid_i),
        .lsu_rdata_i     (lsu_rdata_i),
        .lsu_err_i       (lsu_err_i),
        .raddr_a_i       (raddr_a_i),
        .raddr_b_i       (raddr_b_i),
        .rf_waddr_o      (rf_waddr_o),
        .rf_wdata_o      (rf_wdata_o),
        .rf_we_o         (rf_we_o),
        .fwd_a_valid_o   (fwd_a_valid_o),
        .fwd_b_valid_o   (fwd_b_valid_o),
        .fwd_data_o      (fwd_data_o),
        .hazard_o        (hazard_o),
        .load_err_o      (load_err_o),
        .illegal_waddr_o (illegal_waddr_o),
        .spurious_rsp_o  (spurious_rsp_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid_i   = 1'b0;
        ex_we_i      = 1'b0;
        ex_waddr_i   = '0;
        ex_wdata_i   = '0;
        lsu_req_i    = 1'b0;
        lsu_waddr_i  = '0;
        lsu_rvalid_i = 1'b0;
        lsu_rdata_i  = '0;
        lsu_err_i    = 1'b0;
    endtask

    task automatic ex_write(input logic [4:0] a, input logic [31:0] d);
        ex_valid_i = 1'b1;
        ex_we_i    = 1'b1;
        ex_waddr_i = a;
        ex_wdata_i = d;
    endtask

    task automatic expect_write(input string tag, input logic [4:0] a, input logic [31:0] d);
        check({tag, "_we"},    32'(rf_we_o),    32'd1);
        check({tag, "_waddr"}, 32'(rf_waddr_o), 32'(a));
        check({tag, "_wdata"}, rf_wdata_o,      d);
    endtask

    initial begin
        idle_inputs();
        raddr_a_i = '0;
        raddr_b_i = '0;
        rst_i     = 1'b1;
        tick();
        tick();
        check("rst_we",       32'(rf_we_o),         32'd0);
        check("rst_waddr",    32'(rf_waddr_o),      32'd0);
        check("rst_wdata",    rf_wdata_o,           32'd0);
        check("rst_ready",    32'(lsu_req_ready_o), 32'd1);
        check("rst_pulses",   32'({load_err_o, illegal_waddr_o, spurious_rsp_o}), 32'd0);
        rst_i = 1'b0;
        tick();

        // execute write, then forward it
        ex_write(5'd5, 32'hDEADBEEF);
        settle();
        check("ex_ready", 32'(ex_ready_o), 32'd1);
        tick();
        idle_inputs();
        raddr_a_i = 5'd5;
        raddr_b_i = 5'd6;
        settle();
        expect_write("ex", 5'd5, 32'hDEADBEEF);
        check("fwd_a",    32'(fwd_a_valid_o), 32'd1);
        check("fwd_b_no", 32'(fwd_b_valid_o), 32'd0);
        check("fwd_data", fwd_data_o, 32'hDEADBEEF);
        tick();
        check("ex_one_cycle", 32'(rf_we_o), 32'd0);

        // load hazard
        raddr_a_i   = 5'd0;
        raddr_b_i   = 5'd0;
        lsu_req_i   = 1'b1;
        lsu_waddr_i = 5'd7;
        tick();
        idle_inputs();
        raddr_b_i = 5'd7;
        settle();
        check("hz_set",       32'(hazard_o),        32'd1);
        check("hz_not_ready", 32'(lsu_req_ready_o), 32'd0);
        tick();
        check("hz_hold", 32'(hazard_o), 32'd1);
        lsu_rvalid_i = 1'b1;
        lsu_rdata_i  = 32'h1234;
        settle();
        check("hz_clear_rsp", 32'(hazard_o),        32'd0);
        check("hz_ready_rsp", 32'(lsu_req_ready_o), 32'd1);
        tick();
        idle_inputs();
        settle();
        expect_write("ld", 5'd7, 32'h1234);
        check("ld_fwd_b", 32'(fwd_b_valid_o), 32'd1);
        check("ld_no_hz", 32'(hazard_o),      32'd0);
        raddr_b_i = 5'd0;

        // collision: load response and execute result in the same cycle
        tick();
        lsu_req_i   = 1'b1;
        lsu_waddr_i = 5'd7;
        tick();
        idle_inputs();
        lsu_rvalid_i = 1'b1;
        lsu_rdata_i  = 32'hAA;
        ex_write(5'd3, 32'hBB);
        settle();
        check("col_ex_stall", 32'(ex_ready_o), 32'd0);
        tick();
        lsu_rvalid_i = 1'b0;
        settle();
        expect_write("col_ld", 5'd7, 32'hAA);
        check("col_ex_go", 32'(ex_ready_o), 32'd1);
        tick();
        idle_inputs();
        settle();
        expect_write("col_ex", 5'd3, 32'hBB);

        // drops: x0, RV32E-illegal x20, ex result without we
        tick();
        ex_write(5'd0, 32'h55);
        tick();
        idle_inputs();
        settle();
        check("x0_drop", 32'(rf_we_o), 32'd0);
        ex_write(5'd20, 32'h66);
        tick();
        idle_inputs();
        settle();
        check("x20_drop",  32'(rf_we_o),         32'd0);
        check("x20_pulse", 32'(illegal_waddr_o), 32'd1);
        check("x20_keep",  rf_wdata_o,           32'hBB);
        ex_write(5'd4, 32'h77);
        ex_we_i = 1'b0;
        tick();
        idle_inputs();
        settle();
        check("nowe_drop",  32'(rf_we_o),         32'd0);
        check("x20_pulse1", 32'(illegal_waddr_o), 32'd0);

        // errored load
        lsu_req_i   = 1'b1;
        lsu_waddr_i = 5'd8;
        tick();
        idle_inputs();
        lsu_rvalid_i = 1'b1;
        lsu_err_i    = 1'b1;
        lsu_rdata_i  = 32'h88;
        tick();
        idle_inputs();
        raddr_a_i = 5'd8;
        settle();
        check("err_no_we", 32'(rf_we_o),         32'd0);
        check("err_pulse", 32'(load_err_o),      32'd1);
        check("err_clear", 32'(lsu_req_ready_o), 32'd1);
        check("err_no_hz", 32'(hazard_o),        32'd0);
        tick();
        check("err_pulse1", 32'(load_err_o), 32'd0);
        raddr_a_i = 5'd0;

        // back-to-back loads
        lsu_req_i   = 1'b1;
        lsu_waddr_i = 5'd7;
        tick();
        lsu_waddr_i  = 5'd9;
        lsu_rvalid_i = 1'b1;
        lsu_rdata_i  = 32'h77;
        settle();
        check("b2b_ready", 32'(lsu_req_ready_o), 32'd1);
        tick();
        idle_inputs();
        raddr_a_i = 5'd9;
        settle();
        expect_write("b2b_x7", 5'd7, 32'h77);
        check("b2b_hz",      32'(hazard_o),        32'd1);
        check("b2b_pending", 32'(lsu_req_ready_o), 32'd0);
        lsu_rvalid_i = 1'b1;
        lsu_rdata_i  = 32'h99;
        tick();
        idle_inputs();
        settle();
        expect_write("b2b_x9", 5'd9, 32'h99);
        check("b2b_fwd_a", 32'(fwd_a_valid_o), 32'd1);
        raddr_a_i = 5'd0;

        // reset mid-load, then a response with nothing pending
        tick();
        lsu_req_i   = 1'b1;
        lsu_waddr_i = 5'd7;
        tick();
        idle_inputs();
        rst_i = 1'b1;
        settle();
        check("mid_rst_ready", 32'(lsu_req_ready_o), 32'd1);
        check("mid_rst_we",    32'(rf_we_o),         32'd0);
        tick();
        rst_i = 1'b0;
        tick();
        lsu_rvalid_i = 1'b1;
        lsu_rdata_i  = 32'h42;
        settle();
        check("spur_ex_ready", 32'(ex_ready_o), 32'd1);
        tick();
        idle_inputs();
        settle();
        check("spur_pulse", 32'(spurious_rsp_o), 32'd1);
        check("spur_no_we", 32'(rf_we_o),        32'd0);
        tick();
        check("spur_pulse1", 32'(spurious_rsp_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ibex_rf_wb_stage.md
Name: ibex_rf_wb_stage

Overview:
- Writeback stage directly upstream of the flop-based register file.
- Accepts single-cycle execute results and multi-cycle LSU load responses, and arbitrates between them.
- Drives a registered write port (waddr/wdata/we) into the register file.
- Tracks one outstanding load destination to flag read-after-load hazards to decode.
- Supplies forwarding for the write currently in flight, because the register file updates only at the next clock edge.

Parameters:
- RV32E, 0: when 1, register addresses with bit 4 set are illegal; such writes are dropped and flagged.
- DataWidth, 32: width of the write data and forwarded data.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- ex_valid_i  in  1  execute result valid.
- ex_we_i  in  1  execute result writes a register.
- ex_waddr_i  in  5  execute destination register.
- ex_wdata_i  in  DataWidth  execute result.
- ex_ready_o  out  1  execute result accepted this cycle.
- lsu_req_i  in  1  load issued; destination is lsu_waddr_i.
- lsu_waddr_i  in  5  load destination register.
- lsu_req_ready_o  out  1  load may be issued.
- lsu_rvalid_i  in  1  load response valid.
- lsu_rdata_i  in  DataWidth  load data.
- lsu_err_i  in  1  load response is an error.
- raddr_a_i  in  5  decode read address, port A.
- raddr_b_i  in  5  decode read address, port B.
- rf_waddr_o  out  5  register-file write address.
- rf_wdata_o  out  DataWidth  register-file write data.
- rf_we_o  out  1  register-file write enable.
- fwd_a_valid_o  out  1  port A must use fwd_data_o.
- fwd_b_valid_o  out  1  port B must use fwd_data_o.
- fwd_data_o  out  DataWidth  equals rf_wdata_o.
- hazard_o  out  1  decode must stall.
- load_err_o  out  1  one-cycle pulse on an errored load.
- illegal_waddr_o  out  1  one-cycle pulse on a dropped RV32E-illegal write.
- spurious_rsp_o  out  1  one-cycle pulse on a response with no pending load.

Behaviour:
- Reset: rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0; pending=0, pend_waddr=0; all pulse outputs 0.
- Reset mid-load discards the pending entry.
- Scoreboard states: IDLE (pending=0) and LOAD_PENDING (pending=1, pend_waddr held).
  - IDLE -> LOAD_PENDING on lsu_req_i && lsu_req_ready_o.
  - LOAD_PENDING -> IDLE on lsu_rvalid_i.
  - LOAD_PENDING -> LOAD_PENDING when lsu_rvalid_i and an accepted lsu_req_i arrive in the same cycle; pend_waddr takes the new address.
- lsu_req_ready_o = !pending || lsu_rvalid_i. A lsu_req_i without ready is ignored.
- Arbitration: the LSU response has priority.
  - ex_ready_o = !(lsu_rvalid_i && pending).
  - Upstream holds ex_* stable while ex_ready_o=0.
- Write stage register, latency 1:
  - The write selected in cycle N appears on rf_* in cycle N+1.
  - rf_we_o is high for exactly one cycle per accepted write.
- rf_we_o is forced to 0 when any of these hold:
  - the selected write targets address 0;
  - the selected write is an ex result with ex_we_i=0;
  - the selected write is a load with lsu_err_i=1;
  - RV32E=1 and address bit 4 is set; illegal_waddr_o pulses in cycle N+1.
- lsu_err_i with pending: clears pending, no write, load_err_o pulses in cycle N+1.
- lsu_rvalid_i with pending=0: no write, no state change, spurious_rsp_o pulses in cycle N+1.
- Forwarding (combinational): fwd_a_valid_o = rf_we_o && (rf_waddr_o == raddr_a_i) && (raddr_a_i != 0). Port B is the same with raddr_b_i.
- Hazard (combinational): hazard_o = pending && !lsu_rvalid_i && pend_waddr != 0 && (raddr_a_i == pend_waddr || raddr_b_i == pend_waddr).
  - A response arriving in the current cycle clears the hazard; the data is then reachable by forwarding in the next cycle.

Decomposition:
- Shared package holds:
  - REG_ADDR_W = 5;
  - the scoreboard state enum {WB_IDLE, WB_LOAD_PENDING};
  - a write-request struct {we, waddr, wdata}.
- One natural sub-module: ibex_wb_scoreboard.
  - Contents: the pending flag, pend_waddr, lsu_req_ready_o and hazard_o.
  - The top level holds arbitration, the stage register and forwarding.

Test Plan:
- Execute write: ex_valid_i=1, ex_we_i=1, waddr=5, data=0xDEADBEEF in cycle 0 -> cycle 1: rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0xDEADBEEF; with raddr_a_i=5 in cycle 1, fwd_a_valid_o=1.
- Load hazard: lsu_req_i with waddr=7, then raddr_b_i=7 -> hazard_o=1 and lsu_req_ready_o=0 until lsu_rvalid_i with data 0x1234; the next cycle writes x7=0x1234.
- Collision: lsu_rvalid_i (x7=0xAA) and ex_valid_i (x3=0xBB) in the same cycle -> ex_ready_o=0; writes are x7=0xAA then x3=0xBB on consecutive cycles.
- Drops:
  - write to x0 -> rf_we_o stays 0;
  - RV32E=1 write to x20 -> rf_we_o=0 and illegal_waddr_o pulses;
  - errored load -> no write, load_err_o pulses, pending cleared.
- Back-to-back loads: response for x7 together with a new request to x9 -> x7 written, pending stays 1 with pend_waddr=9.
- Reset: rst_i mid-load; then lsu_rvalid_i -> spurious_rsp_o=1 and no write.
